// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a registered, hold-limited grant.
// Latency: one cycle from request sampled to grant visible; handovers have no idle gap.
module rr_arbiter_16 #(
  parameter int MAX_HOLD_CYCLES = 16
) (
  input  logic        Clk_In,
  input  logic        Rst_n_In,
  input  logic        Enable_In,
  input  logic [15:0] Request_In,
  output logic [15:0] Grant_Out,
  output logic [3:0]  Grant_Index_Out,
  output logic        Grant_Valid_Out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD_CYCLES);

  logic [0:0] state, state_nxt;
  logic [3:0] pointer, pointer_nxt;
  logic [7:0] hold_count, hold_count_nxt;
  logic [3:0] index_nxt;
  logic       release_now;

  // Rotate the request vector so the pointer lands at bit 0, then take the lowest set bit.
  function automatic logic [3:0] pick(input logic [3:0] p, input logic [15:0] r);
    logic [31:0] rot;
    logic [3:0]  off;
    rot = {r, r} >> p;
    off = 4'd0;
    for (int j = 15; j >= 0; j--) begin
      if (rot[j]) off = 4'(j);
    end
    return p + off;
  endfunction

  always_comb begin
    release_now = !Request_In[Grant_Index_Out] || !Enable_In ||
                  ((MAX_HOLD_CYCLES != 0) && (hold_count == HOLD_LIMIT));
  end

  always_comb begin
    state_nxt      = state;
    pointer_nxt    = pointer;
    hold_count_nxt = hold_count;
    index_nxt      = Grant_Index_Out;
    case (state)
      IDLE: begin
        if (Enable_In && (|Request_In)) begin
          state_nxt      = GRANT;
          index_nxt      = pick(pointer, Request_In);
          hold_count_nxt = 8'd1;
        end
      end
      default: begin
        if (release_now) begin
          pointer_nxt = Grant_Index_Out + 4'd1;
          if (Enable_In && (|Request_In)) begin
            index_nxt      = pick(Grant_Index_Out + 4'd1, Request_In);
            hold_count_nxt = 8'd1;
          end else begin
            state_nxt      = IDLE;
            index_nxt      = 4'd0;
            hold_count_nxt = 8'd0;
          end
        end else if (hold_count != 8'hFF) begin
          hold_count_nxt = hold_count + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (!Rst_n_In) begin
      state           <= IDLE;
      pointer         <= 4'd0;
      hold_count      <= 8'd0;
      Grant_Out       <= 16'd0;
      Grant_Index_Out <= 4'd0;
      Grant_Valid_Out <= 1'b0;
    end else begin
      state           <= state_nxt;
      pointer         <= pointer_nxt;
      hold_count      <= hold_count_nxt;
      Grant_Index_Out <= index_nxt;
      Grant_Valid_Out <= (state_nxt == GRANT);
      Grant_Out       <= (state_nxt == GRANT) ? (16'd1 << index_nxt) : 16'd0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Drives a hold-limited (4) and a default (16) arbiter with the same inputs and
// compares both against a cycle-level round-robin reference model.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] request;

  logic [15:0] grant4, grant16;
  logic [3:0]  index4, index16;
  logic        valid4, valid16;

  int n_checks = 0;
  int n_errors = 0;

  int max_hold [2] = '{4, 16};
  int m_owner  [2];
  int m_ptr    [2];
  int m_hold   [2];

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD_CYCLES(4)) u_dut4 (
    .Clk_In(clk), .Rst_n_In(rst_n), .Enable_In(enable), .Request_In(request),
    .Grant_Out(grant4), .Grant_Index_Out(index4), .Grant_Valid_Out(valid4)
  );

  rr_arbiter_16 u_dut16 (
    .Clk_In(clk), .Rst_n_In(rst_n), .Enable_In(enable), .Request_In(request),
    .Grant_Out(grant16), .Grant_Index_Out(index16), .Grant_Valid_Out(valid16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requester found walking upward from p with wrap-around; -1 if none.
  function automatic int ref_pick(input int p, input logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_update(input int k);
    bit rel;
    if (!rst_n) begin
      m_owner[k] = -1; m_ptr[k] = 0; m_hold[k] = 0;
    end else if (m_owner[k] < 0) begin
      if (enable && request != 0) begin
        m_owner[k] = ref_pick(m_ptr[k], request);
        m_hold[k]  = 1;
      end
    end else begin
      rel = !request[m_owner[k]] || !enable ||
            (max_hold[k] != 0 && m_hold[k] == max_hold[k]);
      if (!rel) begin
        if (m_hold[k] < 255) m_hold[k]++;
      end else begin
        m_ptr[k] = (m_owner[k] + 1) % 16;
        if (enable && request != 0) begin
          m_owner[k] = ref_pick(m_ptr[k], request);
          m_hold[k]  = 1;
        end else begin
          m_owner[k] = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] eg;
    logic [3:0]  ei;
    logic        ev;
    for (int k = 0; k < 2; k++) begin
      ev = (m_owner[k] >= 0);
      eg = ev ? (16'd1 << m_owner[k]) : 16'd0;
      ei = ev ? 4'(m_owner[k]) : 4'd0;
      if (k == 0) begin
        check("grant_h4", 32'(grant4), 32'(eg));
        check("index_h4", 32'(index4), 32'(ei));
        check("valid_h4", 32'(valid4), 32'(ev));
      end else begin
        check("grant_h16", 32'(grant16), 32'(eg));
        check("index_h16", 32'(index16), 32'(ei));
        check("valid_h16", 32'(valid16), 32'(ev));
      end
    end
  endtask

  task automatic step(input logic r_n, input logic en, input logic [15:0] req);
    rst_n = r_n; enable = en; request = req;
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 16'h0000);
  endtask

  int exp_order [4] = '{0, 15, 0, 15};

  initial begin
    rst_n = 1'b0; enable = 1'b1; request = 16'hFFFF;
    m_owner = '{-1, -1}; m_ptr = '{0, 0}; m_hold = '{0, 0};

    // Outputs idle through reset even with every requester asking.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'hFFFF);
      check("rst_grant", 32'(grant16), 32'h0);
    end
    step(1'b1, 1'b1, 16'hFFFF);
    check("post_rst_grant", 32'(grant16), 32'h0001);
    check("post_rst_index", 32'(index16), 32'h0);

    // Two requesters each drop three cycles after their grant: 0,15,0,15 with wrap.
    do_reset();
    step(1'b1, 1'b1, 16'h8001);
    for (int g = 0; g < 4; g++) begin
      check("wrap_order", 32'(index16), 32'(exp_order[g]));
      check("wrap_valid", 32'(valid16), 32'h1);
      step(1'b1, 1'b1, 16'h8001);
      step(1'b1, 1'b1, 16'h8001);
      step(1'b1, 1'b1, 16'h8001 & ~(16'd1 << exp_order[g]));
    end

    // Hold limit of 4 alternates between requesters 2 and 5.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step(1'b1, 1'b1, 16'h0024);
      check("hold_valid", 32'(valid4), 32'h1);
      if (c == 4) check("hold_c4", 32'(index4), 32'd2);
      if (c == 5) check("hold_c5", 32'(index4), 32'd5);
      if (c == 8) check("hold_c8", 32'(index4), 32'd5);
      if (c == 9) check("hold_c9", 32'(index4), 32'd2);
    end

    // A sole requester under a hold limit is re-granted without a gap.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1, 16'h0080);
      check("solo_index", 32'(index4), 32'd7);
      check("solo_valid", 32'(valid4), 32'h1);
    end

    // Disable mid-grant to 9; the pointer then sits at 10 and wraps to 0 first.
    do_reset();
    step(1'b1, 1'b1, 16'h0200);
    check("en_grant9", 32'(index16), 32'd9);
    step(1'b1, 1'b0, 16'h0200);
    check("dis_valid", 32'(valid16), 32'h0);
    check("dis_grant", 32'(grant16), 32'h0);
    step(1'b1, 1'b1, 16'h0201);
    check("reen_index", 32'(index16), 32'd0);

    // Reset pulse during a grant to 12 returns the pointer to 0.
    do_reset();
    step(1'b1, 1'b1, 16'h1000);
    check("pre_rst12", 32'(index16), 32'd12);
    step(1'b1, 1'b1, 16'h1002);
    step(1'b0, 1'b1, 16'h1002);
    check("midrst_valid", 32'(valid16), 32'h0);
    step(1'b1, 1'b1, 16'h1002);
    check("midrst_index", 32'(index16), 32'd1);

    // Random traffic: sticky sparse requests, occasional disable and reset.
    begin
      logic [15:0] req_r;
      logic        en_r, rst_r;
      req_r = 16'h0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 3) == 0)
          req_r = 16'($urandom) & 16'($urandom);
        else
          req_r = req_r | (16'd1 << $urandom_range(0, 15)) & 16'($urandom);
        if ($urandom_range(0, 4) == 0)
          req_r = req_r & ~(16'd1 << $urandom_range(0, 15));
        en_r  = ($urandom_range(0, 19) != 0);
        rst_r = ($urandom_range(0, 199) != 0);
        step(rst_r, en_r, req_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one resource between 16 requesters.
- Scan order is lowest-index-first, starting from a rotating pointer, so no requester can be starved.
- The grant is registered and held until the owner drops its request, the hold limit expires, or the arbiter is disabled.
- Sits in front of shared datapath blocks, e.g. a single encoder or output bus used by 16 sources.

Parameters:
- MAX_HOLD_CYCLES, default 16: maximum consecutive cycles one grant may be held. 0 means no limit. Legal range 0..255.

Ports:
- Clk_In  input  1  clock; all state updates on the rising edge.
- Rst_n_In  input  1  synchronous reset, active-low.
- Enable_In  input  1  high allows grants; low forces idle.
- Request_In  input  16  request vector; bit i is requester i.
- Grant_Out  output  16  one-hot grant, all-zero when idle.
- Grant_Index_Out  output  4  binary index of the grantee; 0 when idle.
- Grant_Valid_Out  output  1  high while any grant is active.

Behaviour:
- Reset:
  - Sampled on the Clk_In edge while Rst_n_In=0.
  - State=IDLE, Pointer=0, Hold_Count=0.
  - Grant_Out=0, Grant_Index_Out=0, Grant_Valid_Out=0.
  - Reset asserted mid-grant drops the grant on the next edge; no release bookkeeping is performed and Pointer returns to 0.
- Selection function Pick(P, R):
  - Returns the first set bit of R scanning indices P, P+1, ..., 15, 0, ..., P-1.
  - Ties never occur.
  - Pick is combinational; the grant is registered.
- State IDLE:
  - If Enable_In=1 and Request_In!=0:
    - g=Pick(Pointer, Request_In).
    - Next edge: state=GRANT, Grant_Out=1<<g, Grant_Index_Out=g, Grant_Valid_Out=1, Hold_Count=1.
    - Latency: one cycle from request sampled to grant visible.
  - Otherwise remain in IDLE; outputs stay 0.
- State GRANT (owner g), release conditions:
  - Request_In[g]=0, or
  - MAX_HOLD_CYCLES!=0 and Hold_Count==MAX_HOLD_CYCLES, or
  - Enable_In=0.
- No release:
  - Hold grant.
  - Hold_Count increments, saturating at 255.
  - Pointer unchanged.
  - Other requests are ignored.
- Release with Enable_In=0:
  - Next edge: IDLE, outputs 0.
  - Pointer=(g+1) mod 16.
- Release with Enable_In=1 (back-to-back handover):
  - Pointer=(g+1) mod 16.
  - If Request_In!=0: new owner h=Pick((g+1) mod 16, Request_In), granted on the next edge with Hold_Count=1 and no idle gap.
  - h may equal g only on a timeout release when g is the sole requester; g is then re-granted with Hold_Count=1.
  - If Request_In==0: next edge goes to IDLE.
- Wrap-around: g=15 sets Pointer to 0.
- Request drop and timeout in the same cycle are treated as a single release; behaviour is identical to either alone.
- Grant_Out is always one-hot or zero. Grant_Index_Out and Grant_Valid_Out are always consistent with Grant_Out.
- A request bit must stay high until granted. A requester that deasserts before its grant is simply skipped.
- Requests changing while a grant is held have no effect until the next release.

Test Plan:
- Reset with Request_In=16'hFFFF held, then release reset with Enable_In=1:
  - Outputs stay 0 during reset.
  - One cycle after reset deassertion, grant goes to 0: Grant_Out=16'h0001, Grant_Index_Out=0.
- Request_In=16'h8001, each owner drops its request 3 cycles after its grant:
  - Grant order is 0, 15, 0, 15.
  - Each handover has zero idle cycles.
  - Pointer wraps from 15 to 0.
- MAX_HOLD_CYCLES=4, Request_In=16'h0024 held constant:
  - Index 2 is held for exactly 4 cycles, then index 5 for 4, then index 2.
  - Grant_Valid_Out stays high throughout.
- MAX_HOLD_CYCLES=4, only Request_In[7] set:
  - Index 7 is re-granted every 4 cycles.
  - Grant_Valid_Out never drops.
- Enable_In deasserted during a grant to index 9:
  - Next edge outputs 0.
  - After re-enable with Request_In=16'h0201, index 0 is granted because Pointer=10 wraps past 15 to 0 before reaching 9.
- Rst_n_In pulsed low for one cycle during a grant to index 12 with Request_In=16'h1002:
  - Grant drops.
  - After reset, grant goes to index 1 because Pointer=0.
